// File: rtl/des_region_scheduler.sv
// Sweeps des_block over an inclusive range of regions, reporting each nonzero match count
// through a valid/ready handshake. All outputs come straight from flops.
module des_region_scheduler #(
  parameter int unsigned REGION_W = 16,
  parameter int unsigned COUNT_W  = 10,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                go_i,
  input  logic                abort_i,
  input  logic [REGION_W-1:0] region_first_i,
  input  logic [REGION_W-1:0] region_last_i,
  output logic                des_start_o,
  output logic [REGION_W-1:0] des_region_select_o,
  input  logic [COUNT_W-1:0]  des_counter_i,
  input  logic                des_valid_i,
  output logic                hit_valid_o,
  input  logic                hit_ready_i,
  output logic [REGION_W-1:0] hit_region_o,
  output logic [COUNT_W-1:0]  hit_count_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                range_err_o,
  output logic                timeout_err_o,
  output logic [15:0]         hit_total_o
);

  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLaunch, StWait, StReport, StAdvance} state_e;

  state_e              state_q, state_d;
  logic [REGION_W-1:0] cur_q, cur_d;
  logic [REGION_W-1:0] last_q, last_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [REGION_W-1:0] hit_region_q, hit_region_d;
  logic [COUNT_W-1:0]  hit_count_q, hit_count_d;
  logic [15:0]         hit_total_q, hit_total_d;
  logic                start_q, start_d;
  logic [REGION_W-1:0] sel_q, sel_d;
  logic                hit_valid_q, hit_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                range_err_q, range_err_d;
  logic                timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    timer_d       = timer_q;
    hit_region_d  = hit_region_q;
    hit_count_d   = hit_count_q;
    hit_total_d   = hit_total_q;
    done_d        = 1'b0;
    range_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    // abort overrides every transition; hit_total keeps its value for inspection
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go_i) begin
            if (region_first_i <= region_last_i) begin
              cur_d       = region_first_i;
              last_d      = region_last_i;
              hit_total_d = '0;
              state_d     = StLaunch;
            end else begin
              range_err_d = 1'b1;
            end
          end
        end
        StLaunch: begin
          timer_d = '0;
          state_d = StWait;
        end
        StWait: begin
          if (des_valid_i) begin
            if (des_counter_i != '0) begin
              hit_region_d = cur_q;
              hit_count_d  = des_counter_i;
              if (hit_total_q != 16'hFFFF) begin
                hit_total_d = hit_total_q + 16'd1;
              end
              state_d = StReport;
            end else begin
              state_d = StAdvance;
            end
          end else if (timer_q == TimerLast) begin
            timeout_err_d = 1'b1;
            state_d       = StAdvance;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        StReport: begin
          if (hit_ready_i) begin
            state_d = StAdvance;
          end
        end
        StAdvance: begin
          // cur only advances while below last, so it can never wrap
          if (cur_q == last_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cur_d   = cur_q + 1'b1;
            state_d = StLaunch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they align with it.
  always_comb begin
    start_d     = (state_d == StLaunch);
    busy_d      = (state_d != StIdle);
    hit_valid_d = (state_d == StReport);
    sel_d       = (state_d == StIdle) ? '0 : cur_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cur_q         <= '0;
      last_q        <= '0;
      timer_q       <= '0;
      hit_region_q  <= '0;
      hit_count_q   <= '0;
      hit_total_q   <= '0;
      start_q       <= 1'b0;
      sel_q         <= '0;
      hit_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      range_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      hit_region_q  <= hit_region_d;
      hit_count_q   <= hit_count_d;
      hit_total_q   <= hit_total_d;
      start_q       <= start_d;
      sel_q         <= sel_d;
      hit_valid_q   <= hit_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      range_err_q   <= range_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign des_start_o         = start_q;
  assign des_region_select_o = sel_q;
  assign hit_valid_o         = hit_valid_q;
  assign hit_region_o        = hit_region_q;
  assign hit_count_o         = hit_count_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign range_err_o         = range_err_q;
  assign timeout_err_o       = timeout_err_q;
  assign hit_total_o         = hit_total_q;

endmodule

// File: tb/tb_des_region_scheduler.sv
// Bench for des_region_scheduler: directed sweeps with literal expectations, then random
// stimulus checked every cycle against a behavioural sweep model.
module tb_des_region_scheduler;

  localparam int unsigned RW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          go_i, abort_i, des_valid_i, hit_ready_i;
  logic [RW-1:0] region_first_i, region_last_i;
  logic [CW-1:0] des_counter_i;
  logic          des_start_o, hit_valid_o, busy_o, done_o, range_err_o, timeout_err_o;
  logic [RW-1:0] des_region_select_o, hit_region_o;
  logic [CW-1:0] hit_count_o;
  logic [15:0]   hit_total_o;

  des_region_scheduler #(.REGION_W(RW), .COUNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .go_i               (go_i),
    .abort_i            (abort_i),
    .region_first_i     (region_first_i),
    .region_last_i      (region_last_i),
    .des_start_o        (des_start_o),
    .des_region_select_o(des_region_select_o),
    .des_counter_i      (des_counter_i),
    .des_valid_i        (des_valid_i),
    .hit_valid_o        (hit_valid_o),
    .hit_ready_i        (hit_ready_i),
    .hit_region_o       (hit_region_o),
    .hit_count_o        (hit_count_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .range_err_o        (range_err_o),
    .timeout_err_o      (timeout_err_o),
    .hit_total_o        (hit_total_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Sweep model: phase of the sweep plus the values a reader would expect to see.
  localparam int PIdle = 0, PLaunch = 1, PWait = 2, PReport = 3, PAdvance = 4;
  int          m_ph = PIdle;
  int          m_waited = 0;
  logic [15:0] m_cur = '0, m_last = '0, m_total = '0, m_hr = '0;
  logic [9:0]  m_hc = '0;
  bit          m_done = 0, m_rerr = 0, m_terr = 0;

  // Observation logs for the directed literal checks.
  int          start_cnt = 0, done_cnt = 0, rerr_cnt = 0, terr_cnt = 0;
  int          hv_cnt = 0, busy_cnt = 0;
  logic [15:0] sel_log[$];

  // Inputs change 1 time unit after posedge, so at negedge they already hold the values
  // the next posedge will sample: compare first, then advance the model.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      check("rst_start", 32'(des_start_o), 32'd0);
      check("rst_sel", 32'(des_region_select_o), 32'd0);
      check("rst_hv", 32'(hit_valid_o), 32'd0);
      check("rst_hr", 32'(hit_region_o), 32'd0);
      check("rst_hc", 32'(hit_count_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_pulses", 32'({done_o, range_err_o, timeout_err_o}), 32'd0);
      check("rst_total", 32'(hit_total_o), 32'd0);
      m_ph = PIdle; m_cur = '0; m_last = '0; m_total = '0; m_hr = '0; m_hc = '0;
      m_done = 0; m_rerr = 0; m_terr = 0; m_waited = 0;
    end else begin
      check("des_start", 32'(des_start_o), 32'(m_ph == PLaunch));
      check("busy", 32'(busy_o), 32'(m_ph != PIdle));
      check("hit_valid", 32'(hit_valid_o), 32'(m_ph == PReport));
      if (m_ph != PAdvance)
        check("select", 32'(des_region_select_o), (m_ph == PIdle) ? 32'd0 : 32'(m_cur));
      if (m_ph == PReport) begin
        check("hit_region", 32'(hit_region_o), 32'(m_hr));
        check("hit_count", 32'(hit_count_o), 32'(m_hc));
      end
      check("hit_total", 32'(hit_total_o), 32'(m_total));
      check("done", 32'(done_o), 32'(m_done));
      check("range_err", 32'(range_err_o), 32'(m_rerr));
      check("timeout_err", 32'(timeout_err_o), 32'(m_terr));

      if (des_start_o) begin start_cnt++; sel_log.push_back(des_region_select_o); end
      if (done_o) done_cnt++;
      if (range_err_o) rerr_cnt++;
      if (timeout_err_o) terr_cnt++;
      if (hit_valid_o) hv_cnt++;
      if (busy_o) busy_cnt++;

      m_done = 0; m_rerr = 0; m_terr = 0;
      if (abort_i) begin
        m_ph = PIdle;
      end else begin
        case (m_ph)
          PIdle: if (go_i) begin
            if (region_first_i <= region_last_i) begin
              m_cur = region_first_i; m_last = region_last_i; m_total = '0; m_ph = PLaunch;
            end else m_rerr = 1;
          end
          PLaunch: begin m_waited = 0; m_ph = PWait; end
          PWait: begin
            if (des_valid_i && des_counter_i != 0) begin
              m_hr = m_cur; m_hc = des_counter_i;
              if (m_total != 16'hFFFF) m_total = m_total + 16'd1;
              m_ph = PReport;
            end else if (des_valid_i) begin
              m_ph = PAdvance;
            end else begin
              m_waited++;
              if (m_waited == TO) begin m_terr = 1; m_ph = PAdvance; end
            end
          end
          PReport: if (hit_ready_i) m_ph = PAdvance;
          PAdvance: begin
            if (m_cur == m_last) begin m_done = 1; m_ph = PIdle; end
            else begin m_cur = m_cur + 16'd1; m_ph = PLaunch; end
          end
          default: m_ph = PIdle;
        endcase
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic go_cmd(input logic [15:0] f, input logic [15:0] l);
    region_first_i = f; region_last_i = l; go_i = 1'b1;
    step(1);
    go_i = 1'b0;
  endtask

  int b_start, b_done, b_rerr, b_terr, b_hv, b_busy, b_sel;
  task automatic snap();
    b_start = start_cnt; b_done = done_cnt; b_rerr = rerr_cnt; b_terr = terr_cnt;
    b_hv = hv_cnt; b_busy = busy_cnt; b_sel = sel_log.size();
  endtask

  initial begin
    bit quiet;
    rst_ni = 1'b0; go_i = 1'b0; abort_i = 1'b0; des_valid_i = 1'b0; hit_ready_i = 1'b0;
    region_first_i = '0; region_last_i = '0; des_counter_i = '0;
    step(3);
    rst_ni = 1'b1;
    step(2);

    // Three misses across regions 3..5.
    snap(); des_valid_i = 1'b1; des_counter_i = '0;
    go_cmd(16'd3, 16'd5); step(12); des_valid_i = 1'b0; step(2);
    check("miss_starts", 32'(start_cnt - b_start), 32'd3);
    if (sel_log.size() >= b_sel + 3) begin
      check("miss_sel0", 32'(sel_log[b_sel]), 32'd3);
      check("miss_sel1", 32'(sel_log[b_sel + 1]), 32'd4);
      check("miss_sel2", 32'(sel_log[b_sel + 2]), 32'd5);
    end else check("miss_sel_log", 32'(sel_log.size() - b_sel), 32'd3);
    check("miss_done", 32'(done_cnt - b_done), 32'd1);
    check("miss_total", 32'(hit_total_o), 32'd0);

    // One hit held against a stalled consumer.
    snap(); des_valid_i = 1'b1; des_counter_i = 10'd2; hit_ready_i = 1'b0;
    go_cmd(16'd7, 16'd7); step(8);
    check("hit_hold_cycles", 32'(hv_cnt - b_hv >= 5), 32'd1);
    check("hit_hold_valid", 32'(hit_valid_o), 32'd1);
    check("hit_hold_region", 32'(hit_region_o), 32'd7);
    check("hit_hold_count", 32'(hit_count_o), 32'd2);
    hit_ready_i = 1'b1; step(5); hit_ready_i = 1'b0; des_valid_i = 1'b0;
    check("hit_done", 32'(done_cnt - b_done), 32'd1);
    check("hit_total", 32'(hit_total_o), 32'd1);

    // Reversed range.
    snap(); go_cmd(16'd9, 16'd4); step(3);
    check("range_err_pulses", 32'(rerr_cnt - b_rerr), 32'd1);
    check("range_busy", 32'(busy_cnt - b_busy), 32'd0);
    check("range_starts", 32'(start_cnt - b_start), 32'd0);

    // No responses: each region times out.
    snap(); go_cmd(16'd0, 16'd1); step(2 * (TO + 3) + 6);
    check("timeout_pulses", 32'(terr_cnt - b_terr), 32'd2);
    check("timeout_starts", 32'(start_cnt - b_start), 32'd2);
    check("timeout_done", 32'(done_cnt - b_done), 32'd1);

    // Abort while a hit is being reported, then a fresh sweep.
    snap(); des_valid_i = 1'b1; des_counter_i = 10'd2; hit_ready_i = 1'b0;
    go_cmd(16'd7, 16'd7); step(5);
    abort_i = 1'b1; step(1); abort_i = 1'b0;
    check("abort_hv", 32'(hit_valid_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_total_kept", 32'(hit_total_o), 32'd1);
    step(4);
    check("abort_no_done", 32'(done_cnt - b_done), 32'd0);
    des_counter_i = '0; go_cmd(16'd3, 16'd3); step(6); des_valid_i = 1'b0;
    check("abort_rego_done", 32'(done_cnt - b_done), 32'd1);

    // Top region must not wrap.
    snap(); des_valid_i = 1'b1; des_counter_i = '0;
    go_cmd(16'hFFFF, 16'hFFFF); step(8); des_valid_i = 1'b0;
    check("top_starts", 32'(start_cnt - b_start), 32'd1);
    if (sel_log.size() > b_sel) check("top_sel", 32'(sel_log[b_sel]), 32'hFFFF);
    check("top_done", 32'(done_cnt - b_done), 32'd1);
    check("top_idle_sel", 32'(des_region_select_o), 32'd0);

    // Random traffic; responses are independent of DUT state, so stray valids are exercised.
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] base;
      if (i % 250 == 0) quiet = ($urandom_range(0, 2) == 0);
      base = ($urandom_range(0, 3) == 0) ? 16'hFFF8 : 16'h0000;
      go_i           = ($urandom_range(0, 11) == 0);
      abort_i        = ($urandom_range(0, 79) == 0);
      region_first_i = base + 16'($urandom_range(0, 7));
      region_last_i  = base + 16'($urandom_range(0, 7));
      des_valid_i    = !quiet && ($urandom_range(0, 9) < 3);
      des_counter_i  = ($urandom_range(0, 1) == 0) ? '0 : 10'($urandom_range(0, 1023));
      hit_ready_i    = ($urandom_range(0, 1) == 0);
      if (i == 2000) begin
        rst_ni = 1'b0; step(3); rst_ni = 1'b1;
      end
      step(1);
    end
    go_i = 1'b0; abort_i = 1'b0; des_valid_i = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/des_region_scheduler.md
DES_REGION_SCHEDULER -- requirements
Module: des_region_scheduler

Interface
REQ-001 Parameter REGION_W, default 16, width of region index (matches des_block region_select).
REQ-002 Parameter COUNT_W, default 10, width of des_block match counter.
REQ-003 Parameter TIMEOUT, default 4096, max cycles waiting for des_valid per region.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 go  input  1  single-cycle request to start a sweep; sampled only in IDLE.
REQ-007 abort  input  1  stop the sweep; return to IDLE.
REQ-008 region_first  input  REGION_W  first region of sweep, sampled on accepted go.
REQ-009 region_last  input  REGION_W  last region of sweep, inclusive, sampled on accepted go.
REQ-010 des_start  output  1  one-cycle start pulse to des_block.
REQ-011 des_region_select  output  REGION_W  region driven to des_block.
REQ-012 des_counter  input  COUNT_W  match count from des_block.
REQ-013 des_valid  input  1  des_block result valid.
REQ-014 hit_valid / hit_ready  output / input  1 / 1  hit-report handshake.
REQ-015 hit_region / hit_count  output  REGION_W / COUNT_W  region and nonzero count of reported hit.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when sweep completes normally.
REQ-018 range_err / timeout_err  output  1 / 1  one-cycle error pulses.
REQ-019 hit_total  output  16  hits in current sweep, saturating at 16'hFFFF.

Function
REQ-020 States SHALL be IDLE, LAUNCH, WAIT, REPORT, ADVANCE.
REQ-021 IDLE: go with region_first<=region_last -> latch range, cur<=region_first, clear hit_total, -> LAUNCH next cycle.
REQ-022 IDLE: go with region_first>region_last -> range_err pulse next cycle, stay IDLE, no des_start.
REQ-023 go while busy SHALL be ignored.
REQ-024 des_region_select SHALL equal cur in LAUNCH, WAIT, REPORT; 0 in IDLE.
REQ-025 LAUNCH: des_start=1 for exactly this cycle, clear timeout counter, -> WAIT.
REQ-026 des_valid SHALL be sampled only in WAIT; des_valid in any other state ignored.
REQ-027 WAIT, des_valid=1 and des_counter!=0: capture hit_region=cur, hit_count=des_counter, increment hit_total, -> REPORT.
REQ-028 WAIT, des_valid=1 and des_counter==0: -> ADVANCE.
REQ-029 WAIT, TIMEOUT cycles elapsed with no des_valid: timeout_err pulse, no hit, -> ADVANCE.
REQ-030 REPORT: hit_valid=1, hit_region/hit_count stable until hit_valid&hit_ready; on that cycle -> ADVANCE.
REQ-031 ADVANCE: cur==last -> done pulse next cycle, -> IDLE; else cur<=cur+1, -> LAUNCH.
REQ-032 cur SHALL never wrap: region_last=all-ones terminates at all-ones without overflow.
REQ-033 Latency: go accepted cycle N -> des_start at N+1; miss result -> next des_start 2 cycles after des_valid.
REQ-034 abort SHALL have priority over all transitions: next state IDLE, hit_valid dropped, no done, hit_total retained.
REQ-035 Outputs SHALL be registered; no combinational path input->output except none.

Reset
REQ-036 On rst_n low, immediately: state IDLE, des_start=0, des_region_select=0, hit_valid=0, hit_region=0, hit_count=0, busy=0, done=0, range_err=0, timeout_err=0, hit_total=0.
REQ-037 Reset mid-sweep SHALL discard the sweep; no done after release.

Verification
REQ-038 go, first=3, last=5, des_valid counter=0 each time -> des_start with select 3,4,5, done once, hit_total=0.
REQ-039 go, first=7, last=7, des_valid counter=10'd2, hit_ready held low 5 cycles -> hit_valid held 5+ cycles, hit_region=7, hit_count=2, then done, hit_total=1.
REQ-040 go, first=9, last=4 -> range_err single pulse, busy stays 0, no des_start.
REQ-041 go, first=0, last=1, no des_valid -> timeout_err after TIMEOUT cycles per region (2 pulses), then done.
REQ-042 abort in REPORT with hit_valid high -> hit_valid 0 next cycle, IDLE, no done; new go accepted afterwards.
REQ-043 first=last=16'hFFFF, miss -> single des_start select FFFF, done, no wrap to 0.
